// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: round-robin arbiter that serialises requester words into UART byte transfers
// Ports: clock, reset (sync, active-high); req_valid/req_data/req_ready requester handshake;
//   tx_start/sdata one-cycle byte pulse to the transmitter, tx_busy its busy flag;
//   grant_id requester whose word is in flight; seq_idle high while waiting for a request.
module uart_tx_sequencer #(
  parameter int NUM_REQ = 2,
  parameter int WORD_BYTES = 4,
  localparam int W = 8 * WORD_BYTES,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           sdata,
  input  logic                 tx_busy,
  output logic [GW-1:0]        grant_id,
  output logic                 seq_idle
);
  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;
  state_t state_q, state_d;
  logic [W-1:0] word_q, word_d;
  logic [GW-1:0] grant_q, grant_d, rr_q, rr_d, winner;
  logic [BW-1:0] byte_idx_q, byte_idx_d;
  logic tx_start_q, tx_start_d, found;
  logic [7:0] sdata_q, sdata_d;
  always_comb begin
    found = 1'b0;
    winner = '0;
    // descending scan so the valid requester closest after rr wins
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[GW'((int'(rr_q) + k) % NUM_REQ)]) begin
        found = 1'b1;
        winner = GW'((int'(rr_q) + k) % NUM_REQ);
      end
  end
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    grant_d = grant_q;
    rr_d = rr_q;
    byte_idx_d = byte_idx_q;
    req_ready = '0;
    case (state_q)
      IDLE: if (found && !tx_busy) begin
        req_ready[winner] = 1'b1;
        word_d = req_data[int'(winner)*W +: W];
        grant_d = winner;
        rr_d = GW'((int'(winner) + 1) % NUM_REQ);
        byte_idx_d = '0;
        state_d = START;
      end
      START: state_d = WAIT_HI;
      WAIT_HI: state_d = tx_busy ? WAIT_LO : WAIT_HI;
      WAIT_LO: if (!tx_busy) begin
        state_d = (byte_idx_q == BW'(WORD_BYTES - 1)) ? IDLE : START;
        byte_idx_d = (byte_idx_q == BW'(WORD_BYTES - 1)) ? byte_idx_q : byte_idx_q + BW'(1);
      end
      default: state_d = IDLE;
    endcase
    // pulse and byte are registered so they line up with the START state
    tx_start_d = (state_d == START);
    sdata_d = tx_start_d ? word_d[8*byte_idx_d +: 8] : sdata_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      word_q <= '0;
      grant_q <= '0;
      rr_q <= '0;
      byte_idx_q <= '0;
      tx_start_q <= 1'b0;
      sdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      byte_idx_q <= byte_idx_d;
      tx_start_q <= tx_start_d;
      sdata_q <= sdata_d;
    end
  end
  assign tx_start = tx_start_q;
  assign sdata = sdata_q;
  assign grant_id = grant_q;
  assign seq_idle = (state_q == IDLE);
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: table-driven check of arbitration, byte order and busy pacing
module tb_uart_tx_sequencer;
  logic clock = 1'b0, reset = 1'b1;
  logic [1:0] req_valid = '0, req_ready;
  logic [63:0] req_data = '0;
  logic tx_start, seq_idle, bfm_busy = 1'b0, ext_busy = 1'b0, tx_busy;
  logic [7:0] sdata;
  logic [0:0] grant_id;
  int n_vec = 0, n_err = 0, lat = 1, dur = 1;
  logic [7:0] cap[$];
  assign tx_busy = bfm_busy | ext_busy;
  uart_tx_sequencer #(.NUM_REQ(2), .WORD_BYTES(4)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .sdata(sdata), .tx_busy(tx_busy),
    .grant_id(grant_id), .seq_idle(seq_idle));
  always #5 clock = ~clock;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #2;
  endtask
  // transmitter model: busy rises lat cycles after a pulse and stays up dur cycles
  initial forever begin
    @(negedge clock);
    if (tx_start && !reset) begin
      repeat (lat) @(posedge clock);
      #1 bfm_busy = 1'b1;
      repeat (dur) @(posedge clock);
      #1 bfm_busy = 1'b0;
    end
  end
  // pulse checker: one cycle wide, >=3 cycles apart, busy seen between, never while busy
  initial begin
    logic prev = 1'b0, have_prev = 1'b0, seen_busy = 1'b0;
    int gap = 0;
    forever begin
      @(negedge clock);
      gap++;
      if (tx_busy) seen_busy = 1'b1;
      if (reset) have_prev = 1'b0;
      else if (tx_start) begin
        cap.push_back(sdata);
        chk("pulse_ok", {63'd0, prev || tx_busy || (have_prev && (!seen_busy || gap < 3))}, 64'd0);
        have_prev = 1'b1;
        seen_busy = 1'b0;
        gap = 0;
      end
      prev = tx_start;
    end
  end
  task automatic run_word(input int g, input logic [31:0] w);
    int t = 0;
    logic [1:0] acc;
    logic [31:0] got;
    #1;
    while (req_ready == 2'b00 && t < 500) begin
      tick();
      t++;
    end
    chk("accept_ready", {62'd0, req_ready}, 64'(1 << g));
    acc = req_ready;
    tick();
    req_valid = req_valid & ~acc;
    chk("grant_id", {63'd0, grant_id}, 64'(g));
    chk("busy_not_idle", {63'd0, seq_idle}, 64'd0);
    t = 0;
    while (cap.size() < 4 && t < 2000) begin
      tick();
      t++;
    end
    got = '0;
    for (int i = 0; i < 4 && cap.size() > 0; i++) got[8*i +: 8] = cap.pop_front();
    chk("word_bytes", {32'd0, got}, {32'd0, w});
    t = 0;
    while (!seq_idle && t < 500) begin
      tick();
      t++;
    end
    chk("back_idle", {63'd0, seq_idle}, 64'd1);
  endtask
  typedef struct {
    logic [1:0] mask;
    logic [31:0] d0, d1;
    int lat, dur, g;
    logic [31:0] w;
  } vec_t;
  vec_t tv[7];
  initial begin
    int t;
    tv[0] = '{2'b01, 32'h44332211, 32'h0, 1, 20, 0, 32'h44332211};
    tv[1] = '{2'b11, 32'hA3A2A1A0, 32'hB3B2B1B0, 1, 3, 1, 32'hB3B2B1B0};
    tv[2] = '{2'b11, 32'hA3A2A1A0, 32'hB3B2B1B0, 1, 3, 0, 32'hA3A2A1A0};
    tv[3] = '{2'b11, 32'hA3A2A1A0, 32'hB3B2B1B0, 1, 3, 1, 32'hB3B2B1B0};
    tv[4] = '{2'b11, 32'hA3A2A1A0, 32'hB3B2B1B0, 1, 3, 0, 32'hA3A2A1A0};
    tv[5] = '{2'b10, 32'h0, 32'hB3B2B1B0, 5, 4, 1, 32'hB3B2B1B0};
    tv[6] = '{2'b01, 32'h12345678, 32'hB3B2B1B0, 2, 1, 0, 32'h12345678};
    repeat (3) tick();
    chk("rst_idle", {63'd0, seq_idle}, 64'd1);
    chk("rst_tx_start", {63'd0, tx_start}, 64'd0);
    chk("rst_sdata", {56'd0, sdata}, 64'd0);
    chk("rst_grant", {63'd0, grant_id}, 64'd0);
    chk("rst_ready", {62'd0, req_ready}, 64'd0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      req_data = {tv[i].d1, tv[i].d0};
      req_valid = tv[i].mask;
      lat = tv[i].lat;
      dur = tv[i].dur;
      run_word(tv[i].g, tv[i].w);
    end
    // transmitter busy while idle: no accept until it drops
    ext_busy = 1'b1;
    req_data = {32'h0, 32'h0BADF00D};
    req_valid = 2'b01;
    lat = 1;
    dur = 2;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("busy_idle_ready", {62'd0, req_ready}, 64'd0);
    end
    ext_busy = 1'b0;
    run_word(0, 32'h0BADF00D);
    // reset after the second byte of a word
    req_data = {32'h0, 32'h55667788};
    req_valid = 2'b01;
    #1;
    t = 0;
    while (req_ready == 2'b00 && t < 500) begin
      tick();
      t++;
    end
    chk("rw_accept", {62'd0, req_ready}, 64'd1);
    t = 0;
    while (cap.size() < 2 && t < 500) begin
      tick();
      t++;
    end
    chk("rw_two_bytes", {32'd0, cap[0], cap[1]}, {32'd0, 8'h88, 8'h77});
    reset = 1'b1;
    req_valid = 2'b00;
    tick();
    chk("rw_tx_start", {63'd0, tx_start}, 64'd0);
    chk("rw_idle", {63'd0, seq_idle}, 64'd1);
    chk("rw_sdata", {56'd0, sdata}, 64'd0);
    reset = 1'b0;
    cap.delete();
    repeat (12) tick();
    chk("rw_dropped", 64'(cap.size()), 64'd0);
    req_data = {32'h99AABBCC, 32'h0F0E0D0C};
    req_valid = 2'b11;
    run_word(0, 32'h0F0E0D0C);
    run_word(1, 32'h99AABBCC);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
